// File: rtl/pong_pkg.sv
// pong_pkg: types and centre-position helpers shared by the ball engine and the renderer.
//   state_t  : ball engine FSM states
//   coord_t  : default-width screen coordinate
//   centre_x / centre_y : top-left corner that centres a square ball on the playfield
package pong_pkg;

    localparam int DEF_COORD_W = 10;

    typedef logic [DEF_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PLAY,
        S_SCORED
    } state_t;

    function automatic int centre_x(input int h_res, input int ball_size);
        return (h_res - ball_size) / 2;
    endfunction

    function automatic int centre_y(input int v_res, input int ball_size);
        return (v_res - ball_size) / 2;
    endfunction

endpackage

// File: rtl/pong_frame_counter.sv
// pong_frame_counter: serve-delay down-counter counted in frames.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : reload the counter with FRAMES (wins over tick_i)
//   tick_i     : decrement by one (never below zero)
//   done_o     : counter currently holds 1, i.e. the next tick is the last one
module pong_frame_counter #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic tick_i,
    output logic done_o
);

    localparam int CW = $clog2(FRAMES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? CW'(FRAMES) : (tick_i && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign done_o = cnt_q == CW'(1);

endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame ball motion, wall/paddle bounces, scoring and serve delay.
//   clk, rst_n               : clock, asynchronous active-low reset
//   ena                      : when low, ticks and serves are ignored and state holds
//   frame_tick, serve        : once-per-frame step pulse, serve request
//   paddle_l_y, paddle_r_y   : paddle top edges, sampled on tick edges
//   ball_x, ball_y           : ball top-left corner
//   ball_active, speed       : in PLAY, current step size
//   hit_pulse, score_l_pulse, score_r_pulse : one-cycle event pulses
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_L_X   = 16,
    parameter int PADDLE_R_X   = 616,
    parameter int SPEED_W      = 3,
    parameter int MAX_SPEED    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               frame_tick,
    input  logic               serve,
    input  logic [COORD_W-1:0] paddle_l_y,
    input  logic [COORD_W-1:0] paddle_r_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               ball_active,
    output logic [SPEED_W-1:0] speed,
    output logic               hit_pulse,
    output logic               score_l_pulse,
    output logic               score_r_pulse
);

    // One guard bit so steps past either edge never wrap.
    localparam int W = COORD_W + 1;
    localparam logic [W-1:0] BS    = W'(BALL_SIZE);
    localparam logic [W-1:0] PH    = W'(PADDLE_H);
    localparam logic [W-1:0] Y_MAX = W'(V_RES - BALL_SIZE);
    localparam logic [W-1:0] X_MAX = W'(H_RES - BALL_SIZE);
    localparam logic [W-1:0] L_HIT = W'(PADDLE_L_X + PADDLE_W);
    localparam logic [W-1:0] R_HIT = W'(PADDLE_R_X - BALL_SIZE);
    localparam logic [COORD_W-1:0] CX = COORD_W'(centre_x(H_RES, BALL_SIZE));
    localparam logic [COORD_W-1:0] CY = COORD_W'(centre_y(V_RES, BALL_SIZE));

    state_t state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, x_step, y_step;
    logic [SPEED_W-1:0] speed_q, speed_d, speed_up;
    logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic active_q, active_d, hit_q, hit_d, sl_q, sl_d, sr_q, sr_d;
    logic [W-1:0] xw, yw, sw, pl, pr, nx_l, nx_r, ny_up, ny_dn;
    logic ov_l, ov_r, hit_l, hit_r, sc_l, sc_r, flip_y;
    logic step, recentre, load, cnt_tick, done;

    assign step     = ena && frame_tick && state_q == S_PLAY;
    assign recentre = ena && frame_tick && state_q == S_SCORED;
    assign load     = ena && ((state_q == S_IDLE && serve) || recentre);
    assign cnt_tick = ena && frame_tick && state_q == S_WAIT;

    pong_frame_counter #(.FRAMES(SERVE_FRAMES)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .tick_i (cnt_tick),
        .done_o (done)
    );

    assign xw    = W'(x_q);
    assign yw    = W'(y_q);
    assign sw    = W'(speed_q);
    assign pl    = W'(paddle_l_y);
    assign pr    = W'(paddle_r_y);
    assign nx_l  = xw - sw;
    assign nx_r  = xw + sw;
    assign ny_up = yw - sw;
    assign ny_dn = yw + sw;

    // Vertical overlap uses the pre-step y.
    assign ov_l = (yw + BS > pl) && (yw < pl + PH);
    assign ov_r = (yw + BS > pr) && (yw < pr + PH);

    // A hit needs the ball to start on the field side of the contact line and reach or cross it.
    assign hit_l = !dir_x_q && xw >= L_HIT && nx_l <= L_HIT && ov_l;
    assign hit_r = dir_x_q && xw <= R_HIT && nx_r >= R_HIT && ov_r;
    assign sc_r  = !dir_x_q && !hit_l && xw < sw;
    assign sc_l  = dir_x_q && !hit_r && nx_r > X_MAX;

    assign flip_y   = dir_y_q ? ny_dn > Y_MAX : yw < sw;
    assign y_step   = COORD_W'(flip_y ? (dir_y_q ? Y_MAX : '0) : (dir_y_q ? ny_dn : ny_up));
    assign x_step   = COORD_W'(hit_l ? L_HIT : hit_r ? R_HIT : sc_r ? '0 : sc_l ? X_MAX : dir_x_q ? nx_r : nx_l);
    assign speed_up = speed_q == SPEED_W'(MAX_SPEED) ? speed_q : speed_q + SPEED_W'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (ena)
            case (state_q)
                S_IDLE:   state_d = serve ? S_WAIT : S_IDLE;
                S_WAIT:   state_d = (frame_tick && done) ? S_PLAY : S_WAIT;
                S_PLAY:   state_d = (frame_tick && (sc_l || sc_r)) ? S_SCORED : S_PLAY;
                default:  state_d = frame_tick ? S_WAIT : S_SCORED;
            endcase
    end

    // dir_x is left untouched on a score, so after recentring it points at the conceding side.
    always_comb begin
        x_d      = recentre ? CX : step ? x_step : x_q;
        y_d      = recentre ? CY : step ? y_step : y_q;
        dir_x_d  = step ? (hit_l || (dir_x_q && !hit_r)) : dir_x_q;
        dir_y_d  = step ? dir_y_q ^ flip_y : dir_y_q;
        speed_d  = recentre ? SPEED_W'(1) : (step && (hit_l || hit_r)) ? speed_up : speed_q;
        hit_d    = step && (hit_l || hit_r);
        sl_d     = step && sc_l;
        sr_d     = step && sc_r;
        active_d = state_d == S_PLAY;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x_q      <= CX;
            y_q      <= CY;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            speed_q  <= SPEED_W'(1);
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            sl_q     <= 1'b0;
            sr_q     <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            speed_q  <= speed_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
        end

    assign ball_x        = x_q;
    assign ball_y        = y_q;
    assign ball_active   = active_q;
    assign speed         = speed_q;
    assign hit_pulse     = hit_q;
    assign score_l_pulse = sl_q;
    assign score_r_pulse = sr_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed vector table plus hand sequences for miss/score and async reset.
module tb_pong_ball_engine;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, frame_tick = 1'b0, serve = 1'b0;
    logic [9:0] paddle_l_y = '0, paddle_r_y = '0, ball_x, ball_y;
    logic [2:0] speed;
    logic       ball_active, hit_pulse, score_l_pulse, score_r_pulse;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .frame_tick    (frame_tick),
        .serve         (serve),
        .paddle_l_y    (paddle_l_y),
        .paddle_r_y    (paddle_r_y),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .ball_active   (ball_active),
        .speed         (speed),
        .hit_pulse     (hit_pulse),
        .score_l_pulse (score_l_pulse),
        .score_r_pulse (score_r_pulse)
    );

    typedef struct {
        int tick, srv, en, reps, ex, ey, sp, act, hit;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic s);
        frame_tick = t;
        serve = s;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        serve = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic chk_ball(input string nm, input int ex, input int ey, input int sp, input int act);
        chk({nm, ".x"}, int'(ball_x), ex);
        chk({nm, ".y"}, int'(ball_y), ey);
        chk({nm, ".speed"}, int'(speed), sp);
        chk({nm, ".active"}, int'(ball_active), act);
    endtask

    initial begin
        // Rightward to the right paddle (t=292), back left at speed 2 off the top wall, hit left paddle.
        vt = '{
            '{0, 0, 1, 1,   316, 236, 1, 0, 0},
            '{1, 1, 0, 1,   316, 236, 1, 0, 0},
            '{1, 1, 1, 1,   316, 236, 1, 0, 0},
            '{1, 0, 1, 59,  316, 236, 1, 0, 0},
            '{1, 0, 0, 5,   316, 236, 1, 0, 0},
            '{0, 1, 1, 1,   316, 236, 1, 0, 0},
            '{1, 0, 1, 1,   316, 236, 1, 1, 0},
            '{1, 0, 1, 3,   319, 239, 1, 1, 0},
            '{1, 0, 0, 5,   319, 239, 1, 1, 0},
            '{0, 0, 1, 1,   319, 239, 1, 1, 0},
            '{1, 0, 1, 233, 552, 472, 1, 1, 0},
            '{1, 0, 1, 1,   553, 472, 1, 1, 0},
            '{1, 0, 1, 1,   554, 471, 1, 1, 0},
            '{1, 0, 1, 53,  607, 418, 1, 1, 0},
            '{1, 0, 1, 1,   608, 417, 2, 1, 1},
            '{1, 0, 1, 1,   606, 415, 2, 1, 0},
            '{1, 0, 1, 207, 192, 1,   2, 1, 0},
            '{1, 0, 1, 1,   190, 0,   2, 1, 0},
            '{1, 0, 1, 1,   188, 2,   2, 1, 0},
            '{1, 0, 1, 81,  26,  164, 2, 1, 0},
            '{1, 0, 1, 1,   24,  166, 3, 1, 1},
            '{1, 0, 1, 1,   27,  169, 3, 1, 0}
        };

        paddle_l_y = 10'd154;
        paddle_r_y = 10'd400;
        repeat (3) @(posedge clk);
        #1;
        chk_ball("reset", 316, 236, 1, 0);
        chk("reset.pulses", int'({hit_pulse, score_l_pulse, score_r_pulse}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            ena = vt[i].en[0];
            for (int r = 0; r < vt[i].reps; r++) begin
                cyc(vt[i].tick[0], vt[i].srv[0]);
                if (r != vt[i].reps - 1) cyc(1'b0, 1'b0);
            end
            chk_ball($sformatf("v%0d", i), vt[i].ex, vt[i].ey, vt[i].sp, vt[i].act);
            chk($sformatf("v%0d.hit", i), int'(hit_pulse), vt[i].hit);
            chk($sformatf("v%0d.score", i), int'({score_l_pulse, score_r_pulse}), 0);
            cyc(1'b0, 1'b0);
            chk($sformatf("v%0d.clear", i), int'({hit_pulse, score_l_pulse, score_r_pulse}), 0);
        end

        // Async reset in the middle of a cycle while in PLAY.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_ball("async_rst", 316, 236, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Miss on the left: same rightward trip, left paddle parked off the field.
        ena = 1'b1;
        paddle_l_y = 10'd600;
        cyc(1'b0, 1'b1);
        run(59);
        chk("miss.wait_active", int'(ball_active), 0);
        run(1);
        chk_ball("miss.serve", 316, 236, 1, 1);
        run(292);
        chk_ball("miss.rhit", 608, 417, 2, 1);
        run(291);
        chk_ball("miss.near", 26, 164, 2, 1);
        cyc(1'b1, 1'b0);
        chk_ball("miss.pass", 24, 166, 2, 1);
        chk("miss.pass.hit", int'(hit_pulse), 0);
        cyc(1'b0, 1'b0);
        run(11);
        chk_ball("miss.x2", 2, 188, 2, 1);
        cyc(1'b1, 1'b0);
        chk_ball("miss.x0", 0, 190, 2, 1);
        chk("miss.x0.score_r", int'(score_r_pulse), 0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk_ball("miss.score", 0, 192, 2, 0);
        chk("miss.score_r", int'(score_r_pulse), 1);
        chk("miss.score_l", int'(score_l_pulse), 0);
        cyc(1'b0, 1'b0);
        chk("miss.score_r.clear", int'(score_r_pulse), 0);
        cyc(1'b1, 1'b0);
        chk_ball("recentre", 316, 236, 1, 0);
        chk("recentre.score_r", int'(score_r_pulse), 0);
        cyc(1'b0, 1'b0);
        run(59);
        chk("reserve.wait_active", int'(ball_active), 0);
        run(1);
        chk("reserve.active", int'(ball_active), 1);
        run(1);
        chk_ball("reserve.dir_left", 315, 237, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
